// File: rtl/batalha_rounds.sv
// ----------------------------------------------------------------------------
// batalha_rounds
// Multi-round two-player pattern battle. P1 commits a W-bit pattern, then P2
// guesses the pattern rotated right by ROT. Each round is judged, scored and
// counted. After ROUNDS rounds the game ends and a winner is declared.
//
// Optional feature macro: BATALHA_TIMEOUT_EN
//   When defined, a round with no P2 guess within TIMEOUT cycles is scored
//   as a P1 win. This option also adds the timeout_flag output.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start                begin a new game (accepted in IDLE or DONE only)
//   p1_valid/p1_pattern  P1 pattern handshake; p1_ready is high in WAIT_P1
//   p2_valid/p2_guess    P2 guess handshake;   p2_ready is high in WAIT_P2
//   s1, s2, round_done   one-cycle pulses for the round just judged
//   score1, score2       round wins per player
//   round_cnt            rounds completed in this game
//   game_over            high in DONE
//   winner               00 none, 01 P1, 10 P2, 11 tie (valid in DONE)
//   timeout_flag         (BATALHA_TIMEOUT_EN only) pulses with s1 on timeout
// ----------------------------------------------------------------------------
module batalha_rounds #(
    parameter int W       = 3,
    parameter int ROT     = 1,
    parameter int ROUNDS  = 5,
    parameter int TIMEOUT = 15,
    localparam int SW     = $clog2(ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          p1_valid,
    input  logic [W-1:0]  p1_pattern,
    output logic          p1_ready,
    input  logic          p2_valid,
    input  logic [W-1:0]  p2_guess,
    output logic          p2_ready,
    output logic          s1,
    output logic          s2,
    output logic          round_done,
    output logic [SW-1:0] score1,
    output logic [SW-1:0] score2,
    output logic [SW-1:0] round_cnt,
    output logic          game_over,
`ifdef BATALHA_TIMEOUT_EN
    output logic          timeout_flag,
`endif
    output logic [1:0]    winner
);

    // Elaboration-time sanity check of the parameter ranges.
    localparam bit PARAMS_OK = (W >= 2) && (ROT >= 0) && (ROT < W) &&
                               (ROUNDS >= 1) && (TIMEOUT >= 1);
    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("batalha_rounds: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_P1 = 2'd1,
        WAIT_P2 = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [SW-1:0] score1_q, score1_d;
    logic [SW-1:0] score2_q, score2_d;
    logic [SW-1:0] round_cnt_q, round_cnt_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          round_done_q, round_done_d;

`ifdef BATALHA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;
`endif

    // Expected guess: rotate the committed pattern right by ROT.
    logic [W-1:0] expected;
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_rot
            assign expected[gi] = pat_q[(gi + ROT) % W];
        end
    endgenerate

    logic uniform;
    assign uniform = (pat_q == '0) || (pat_q == '1);

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        round_cnt_d  = round_cnt_q;
        s1_d         = 1'b0;
        s2_d         = 1'b0;
        round_done_d = 1'b0;
`ifdef BATALHA_TIMEOUT_EN
        to_cnt_d     = '0;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    round_cnt_d = '0;
                    pat_d       = '0;
                    state_d     = WAIT_P1;
                end
            end
            WAIT_P1: begin
                if (p1_valid) begin
                    pat_d   = p1_pattern;
                    state_d = WAIT_P2;
                end
            end
            WAIT_P2: begin
                if (p2_valid) begin
                    // Uniform patterns are unbeatable, so s1 wins over a match.
                    if (uniform) begin
                        s1_d     = 1'b1;
                        score1_d = score1_q + 1'b1;
                    end else if (p2_guess == expected) begin
                        s2_d     = 1'b1;
                        score2_d = score2_q + 1'b1;
                    end
                    round_done_d = 1'b1;
                    round_cnt_d  = round_cnt_q + 1'b1;
                    state_d      = (round_cnt_d == SW'(ROUNDS)) ? DONE : WAIT_P1;
`ifdef BATALHA_TIMEOUT_EN
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    // Final allowed cycle passed without a guess: P1 takes it.
                    s1_d         = 1'b1;
                    timeout_d    = 1'b1;
                    score1_d     = score1_q + 1'b1;
                    round_done_d = 1'b1;
                    round_cnt_d  = round_cnt_q + 1'b1;
                    state_d      = (round_cnt_d == SW'(ROUNDS)) ? DONE : WAIT_P1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pat_q        <= '0;
            score1_q     <= '0;
            score2_q     <= '0;
            round_cnt_q  <= '0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            round_done_q <= 1'b0;
`ifdef BATALHA_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            round_cnt_q  <= round_cnt_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            round_done_q <= round_done_d;
`ifdef BATALHA_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign p1_ready   = (state_q == WAIT_P1);
    assign p2_ready   = (state_q == WAIT_P2);
    assign game_over  = (state_q == DONE);
    assign s1         = s1_q;
    assign s2         = s2_q;
    assign round_done = round_done_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign round_cnt  = round_cnt_q;
`ifdef BATALHA_TIMEOUT_EN
    assign timeout_flag = timeout_q;
`endif

    always_comb begin
        winner = 2'b00;
        if (state_q == DONE) begin
            if (score1_q > score2_q)      winner = 2'b01;
            else if (score2_q > score1_q) winner = 2'b10;
            else                          winner = 2'b11;
        end
    end

endmodule
